// File: rtl/atm_keypad_frontend_if.sv
// Controller-facing bundle of the ATM keypad front end: mode select in, digit/amount strobes out.
interface atm_keypad_frontend_if;
    logic        modo_monto;
    logic [3:0]  digito;
    logic        digito_stb;
    logic        add_digit;
    logic [31:0] monto;
    logic        monto_stb;
    logic        monto_err;
    logic        beep;

    modport master (
        input  modo_monto,
        output digito, digito_stb, add_digit, monto, monto_stb, monto_err, beep
    );

    modport slave (
        output modo_monto,
        input  digito, digito_stb, add_digit, monto, monto_stb, monto_err, beep
    );
endinterface

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: 4x4 matrix scan, debounce, PIN digit strobes and decimal amount entry.
// The key-accept beep is compiled in only when ATM_KEYPAD_BEEP_EN is defined.
module atm_keypad_frontend #(
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned DEB_CYCLES  = 5000,
    parameter int unsigned MAX_DIGITS  = 9,
    parameter int unsigned BEEP_CYCLES = 2000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            kp_row_i,
    output logic [3:0]            kp_col_o,
    atm_keypad_frontend_if.master ctrl
);
    localparam int unsigned CNT_MAX   = (SCAN_DIV - 1 > DEB_CYCLES) ? SCAN_DIV - 1 : DEB_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [3:0]  KEY_CLEAR = 4'd12;
    localparam logic [3:0]  KEY_ENTER = 4'd14;

    if (SCAN_DIV < 1 || DEB_CYCLES < 1 || MAX_DIGITS < 1 || MAX_DIGITS > 15 || BEEP_CYCLES < 1)
    begin : g_param_check
        $error("atm_keypad_frontend: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_SCAN, ST_DEB_PRESS, ST_ACCEPT, ST_WAIT_REL, ST_DEB_REL
    } state_e;

    state_e           state_q;
    logic [1:0]       col_q;
    logic [1:0]       row_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic [31:0]      acc_q;
    logic [3:0]       ndig_q;
    logic [3:0]       digito_q;
    logic             digito_stb_q;
    logic [31:0]      monto_q;
    logic             monto_stb_q;
    logic             monto_err_q;

    logic [1:0]  low_row;
    logic        row_pressed;
    logic [3:0]  key_code;
    logic        key_is_digit;
    logic [3:0]  key_digit;
    logic [35:0] acc_ext;
    logic        digit_ok;
    logic        mode_chg;

    assign kp_col_o    = ~(4'b0001 << col_q);
    assign row_pressed = ~kp_row_i[row_q];
    assign key_code    = {row_q, col_q};
    assign mode_chg    = ctrl.modo_monto != mode_q;

    // Wide product so the overflow test stays exact whatever MAX_DIGITS is.
    assign acc_ext  = 36'(acc_q) * 36'd10 + 36'(key_digit);
    assign digit_ok = (ndig_q < 4'(MAX_DIGITS)) && (acc_ext <= 36'h0_FFFF_FFFF);

    always_comb begin
        // NOTE: defaults first so no path through the block leaves a latch behind.
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!kp_row_i[i]) low_row = 2'(i);
        end
    end

    always_comb begin
        key_is_digit = 1'b1;
        key_digit    = 4'd0;
        case (key_code)
            4'd0:    key_digit = 4'd1;
            4'd1:    key_digit = 4'd2;
            4'd2:    key_digit = 4'd3;
            4'd4:    key_digit = 4'd4;
            4'd5:    key_digit = 4'd5;
            4'd6:    key_digit = 4'd6;
            4'd8:    key_digit = 4'd7;
            4'd9:    key_digit = 4'd8;
            4'd10:   key_digit = 4'd9;
            4'd13:   key_digit = 4'd0;
            default: key_is_digit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_SCAN;
            col_q        <= 2'd0;
            row_q        <= 2'd0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            acc_q        <= '0;
            ndig_q       <= '0;
            digito_q     <= '0;
            digito_stb_q <= 1'b0;
            monto_q      <= '0;
            monto_stb_q  <= 1'b0;
            monto_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere; strobes default low so they can only last one cycle.
            digito_stb_q <= 1'b0;
            monto_stb_q  <= 1'b0;
            monto_err_q  <= 1'b0;
            mode_q       <= ctrl.modo_monto;

            case (state_q)
                ST_SCAN: begin
                    if (kp_row_i != 4'hF) begin
                        row_q   <= low_row;
                        cnt_q   <= '0;
                        state_q <= ST_DEB_PRESS;
                    end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                        col_q <= col_q + 2'd1;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!row_pressed) begin
                        cnt_q   <= '0;
                        state_q <= ST_SCAN;
                    end else if (cnt_q == CNT_W'(DEB_CYCLES)) begin
                        cnt_q   <= '0;
                        state_q <= ST_ACCEPT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ACCEPT: begin
                    state_q <= ST_WAIT_REL;
                    if (!ctrl.modo_monto) begin
                        if (key_is_digit) begin
                            digito_q     <= key_digit;
                            digito_stb_q <= 1'b1;
                        end
                    end else if (key_is_digit) begin
                        if (digit_ok) begin
                            acc_q  <= acc_ext[31:0];
                            ndig_q <= ndig_q + 4'd1;
                        end else begin
                            monto_err_q <= 1'b1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        monto_q     <= acc_q;
                        monto_stb_q <= 1'b1;
                        acc_q       <= '0;
                        ndig_q      <= '0;
                    end else if (key_code == KEY_CLEAR) begin
                        acc_q  <= '0;
                        ndig_q <= '0;
                    end
                end
                ST_WAIT_REL: begin
                    if (!row_pressed) begin
                        cnt_q   <= '0;
                        state_q <= ST_DEB_REL;
                    end
                end
                ST_DEB_REL: begin
                    if (row_pressed) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_REL;
                    end else if (cnt_q == CNT_W'(DEB_CYCLES)) begin
                        cnt_q   <= '0;
                        state_q <= ST_SCAN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase

            // A mode flip discards the partial amount and overrides any same-cycle digit update.
            if (mode_chg) begin
                acc_q  <= '0;
                ndig_q <= '0;
            end
        end
    end

    assign ctrl.digito     = digito_q;
    assign ctrl.digito_stb = digito_stb_q;
    assign ctrl.add_digit  = digito_stb_q;
    assign ctrl.monto      = monto_q;
    assign ctrl.monto_stb  = monto_stb_q;
    assign ctrl.monto_err  = monto_err_q;

`ifdef ATM_KEYPAD_BEEP_EN
    localparam int unsigned BEEP_W = $clog2(BEEP_CYCLES + 1);

    logic [BEEP_W-1:0] beep_cnt_q;
    logic              beep_q;

    // Beep rises with the strobe cycle and any new accept restarts the full length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
        end else if (state_q == ST_ACCEPT) begin
            beep_cnt_q <= BEEP_W'(BEEP_CYCLES - 1);
            beep_q     <= 1'b1;
        end else if (beep_cnt_q != '0) begin
            beep_cnt_q <= beep_cnt_q - 1'b1;
        end else begin
            beep_q <= 1'b0;
        end
    end

    assign ctrl.beep = beep_q;
`else
    assign ctrl.beep = 1'b0;
`endif
endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and random keys vs. a keypad model.
module tb_atm_keypad_frontend;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int BEEP_LEN = 6;

    typedef enum {EV_NONE, EV_DIGIT, EV_MONTO, EV_ERR} ev_e;
    typedef struct {
        bit              md;
        int              code;
        ev_e             k9;
        longint unsigned v9;
        ev_e             k10;
        longint unsigned v10;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mode = 1'b0;
    logic [3:0] row9, row10, col9, col10;
    int pressed = -1;

    atm_keypad_frontend_if if9 ();
    atm_keypad_frontend_if if10 ();
    assign if9.modo_monto  = mode;
    assign if10.modo_monto = mode;

    atm_keypad_frontend #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB), .MAX_DIGITS(9), .BEEP_CYCLES(BEEP_LEN))
        u_dut9 (.clk(clk), .rst(rst), .kp_row_i(row9), .kp_col_o(col9), .ctrl(if9));
    atm_keypad_frontend #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB), .MAX_DIGITS(10), .BEEP_CYCLES(BEEP_LEN))
        u_dut10 (.clk(clk), .rst(rst), .kp_row_i(row10), .kp_col_o(col10), .ctrl(if10));

    always #5 clk = ~clk;

    // Physical matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        row9  = 4'hF;
        row10 = 4'hF;
        if (pressed >= 0) begin
            if (!col9[pressed[1:0]])  row9[pressed[3:2]]  = 1'b0;
            if (!col10[pressed[1:0]]) row10[pressed[3:2]] = 1'b0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int aux_bad  = 0;
    int n_dig[2], n_mon[2], n_err[2];
    logic [3:0]  lv_dig[2];
    logic [31:0] lv_mon[2];
    logic prev_ds[2], prev_ms[2], prev_me[2];

    string keys = "123x456x789xC0Ex";
    longint unsigned m_acc[2], m_mon[2];
    int m_cnt[2];
    int m_max[2] = '{9, 10};
    vec_t tbl[$];

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic sample(input int i, input logic ds, input logic ad, input logic [3:0] d,
                          input logic ms, input logic [31:0] m, input logic me, input logic bp);
        if (ds === 1'b1) begin n_dig[i]++; lv_dig[i] = d; end
        if (ms === 1'b1) begin n_mon[i]++; lv_mon[i] = m; end
        if (me === 1'b1) n_err[i]++;
        if (ad !== ds) aux_bad++;
        if ((ds && prev_ds[i]) || (ms && prev_ms[i]) || (me && prev_me[i])) aux_bad++;
`ifndef ATM_KEYPAD_BEEP_EN
        if (bp !== 1'b0) aux_bad++;
`endif
        prev_ds[i] = ds;
        prev_ms[i] = ms;
        prev_me[i] = me;
    endtask

    always @(negedge clk) begin
        sample(0, if9.digito_stb, if9.add_digit, if9.digito, if9.monto_stb, if9.monto, if9.monto_err, if9.beep);
        sample(1, if10.digito_stb, if10.add_digit, if10.digito, if10.monto_stb, if10.monto, if10.monto_err, if10.beep);
    end

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            n_dig[i] = 0; n_mon[i] = 0; n_err[i] = 0;
        end
    endtask

    function automatic int code_of(input byte ch);
        for (int j = 0; j < 16; j++) if (keys[j] == ch) return j;
        return 3;
    endfunction

    function automatic logic [31:0] monto_of(input int i);
        return (i == 0) ? if9.monto : if10.monto;
    endfunction

    task automatic add(input bit md, input byte ch, input ev_e k9, input longint unsigned v9,
                       input ev_e k10, input longint unsigned v10);
        tbl.push_back('{md: md, code: code_of(ch), k9: k9, v9: v9, k10: k10, v10: v10});
    endtask

    task automatic add_same(input bit md, input byte ch, input ev_e k, input longint unsigned v);
        add(md, ch, k, v, k, v);
    endtask

    task automatic add_str(input bit md, input string s);
        for (int j = 0; j < s.len(); j++) add_same(md, s[j], EV_NONE, 0);
    endtask

    // Keypad calculator model: what the controller should see for one key in the given mode.
    task automatic model_key(input int i, input bit md, input int code,
                             output ev_e k, output longint unsigned v);
        byte ch = keys[code];
        bit  is_dig = (ch >= 48) && (ch <= 57);
        int  dv = int'(ch) - 48;
        k = EV_NONE;
        v = 0;
        if (!md) begin
            if (is_dig) begin k = EV_DIGIT; v = longint'(dv); end
        end else if (is_dig) begin
            if (m_cnt[i] < m_max[i] && m_acc[i] * 10 + longint'(dv) <= 64'd4294967295) begin
                m_acc[i] = m_acc[i] * 10 + longint'(dv);
                m_cnt[i]++;
            end else begin
                k = EV_ERR;
            end
        end else if (ch == "E") begin
            k = EV_MONTO;
            v = m_acc[i];
            m_mon[i] = m_acc[i];
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end else if (ch == "C") begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic model_reset(input bit keep_mon);
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_cnt[i] = 0;
            if (!keep_mon) m_mon[i] = 0;
        end
    endtask

    task automatic apply_key(input bit md, input int code);
        if (mode != md) begin
            @(negedge clk);
            mode = md;
            model_reset(1'b1);
            repeat (3) @(negedge clk);
        end
        clear_counts();
        pressed = code;
        repeat (40) @(negedge clk);
        pressed = -1;
        repeat (20) @(negedge clk);
    endtask

    task automatic check_events(input string name, input int i, input ev_e k, input longint unsigned v);
        bit ok;
        int tot = n_dig[i] + n_mon[i] + n_err[i];
        case (k)
            EV_NONE:  ok = (tot == 0);
            EV_DIGIT: ok = (tot == 1) && (n_dig[i] == 1) && (64'(lv_dig[i]) == v);
            EV_MONTO: ok = (tot == 1) && (n_mon[i] == 1) && (64'(lv_mon[i]) == v);
            default:  ok = (tot == 1) && (n_err[i] == 1);
        endcase
        check(name, ok, $sformatf("dut%0d got dig=%0d mon=%0d err=%0d digito=%0d monto=%0d, want %s val=%0d",
              i, n_dig[i], n_mon[i], n_err[i], lv_dig[i], lv_mon[i], k.name(), v));
        check({name, "_monto_hold"}, 64'(monto_of(i)) == m_mon[i],
              $sformatf("dut%0d monto=%0d want %0d", i, monto_of(i), m_mon[i]));
    endtask

    task automatic wait_col(input logic [3:0] want);
        bit ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (col9 == want) ok = 1;
        end
        check("wait_col", ok, $sformatf("kp_col=%b never reached %b", col9, want));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_e k;
        longint unsigned v;
        int n;
        bit seen;
        int bl;

        clear_counts();
        model_reset(1'b0);

        // Reset state
        #12;
        check("reset_kp_col", col9 == 4'b1110, $sformatf("kp_col=%b want 1110", col9));
        check("reset_outputs", {if9.digito, if9.digito_stb, if9.add_digit, if9.monto, if9.monto_stb,
              if9.monto_err, if9.beep} == '0,
              $sformatf("digito=%0d monto=%0d stb=%b%b%b%b beep=%b want all 0", if9.digito, if9.monto,
              if9.digito_stb, if9.add_digit, if9.monto_stb, if9.monto_err, if9.beep));

        // Column scan timing
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("scan_hold", col9 == 4'b1110, $sformatf("kp_col=%b want 1110", col9));
        @(posedge clk);
        #1 check("scan_col1", col9 == 4'b1101, $sformatf("kp_col=%b want 1101", col9));
        repeat (4) @(posedge clk);
        #1 check("scan_col2", col9 == 4'b1011, $sformatf("kp_col=%b want 1011", col9));

        // Press-to-strobe latency: first SCAN edge seeing the row is edge 1, strobe DEB+2 edges later
        wait_col(4'b1110);
        clear_counts();
        pressed = 0;
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (if9.digito_stb) seen = 1;
        end
        check("latency", seen && n == DEB + 3, $sformatf("strobe after %0d edges (seen=%0d) want %0d", n, seen, DEB + 3));
        check("latency_digit", if9.digito == 4'd1, $sformatf("digito=%0d want 1", if9.digito));
`ifdef ATM_KEYPAD_BEEP_EN
        bl = 0;
        while (if9.beep && bl < 50) begin
            bl++;
            @(posedge clk);
            #1;
        end
        check("beep_len", bl == BEEP_LEN, $sformatf("beep high %0d cycles want %0d", bl, BEEP_LEN));
`else
        bl = 0;
`endif
        repeat (30) @(negedge clk);
        pressed = -1;
        repeat (20) @(negedge clk);
        check_events("latency_once", 0, EV_DIGIT, 1);

        // Short press: released mid-debounce, scan resumes from the frozen column
        wait_col(4'b1101);
        clear_counts();
        pressed = 5;
        repeat (5) @(negedge clk);
        pressed = -1;
        repeat (6) @(negedge clk);
        check("short_scan_resume", col9 == 4'b1011, $sformatf("kp_col=%b want 1011", col9));
        repeat (30) @(negedge clk);
        check_events("short_press", 0, EV_NONE, 0);

        // Directed vector table
        add_same(0, "5", EV_DIGIT, 5);
        add_same(0, "0", EV_DIGIT, 0);
        add_same(0, "E", EV_NONE, 0);
        add_same(0, "x", EV_NONE, 0);
        add_same(0, "9", EV_DIGIT, 9);
        add_str(1, "4500");
        add_same(1, "E", EV_MONTO, 4500);
        add_same(1, "E", EV_MONTO, 0);
        add_same(1, "x", EV_NONE, 0);
        add_str(1, "77");
        add_same(0, "C", EV_NONE, 0);
        add_same(1, "E", EV_MONTO, 0);
        add_str(1, "77C3");
        add_same(1, "E", EV_MONTO, 3);
        add_str(1, "429496729");
        add_same(1, "6", EV_ERR, 0);
        add_same(1, "E", EV_MONTO, 429496729);
        add_str(1, "429496729");
        add(1, "5", EV_ERR, 0, EV_NONE, 0);
        add(1, "E", EV_MONTO, 429496729, EV_MONTO, 64'd4294967295);

        foreach (tbl[t]) begin
            apply_key(tbl[t].md, tbl[t].code);
            model_key(0, tbl[t].md, tbl[t].code, k, v);
            model_key(1, tbl[t].md, tbl[t].code, k, v);
            check_events($sformatf("vec%0d", t), 0, tbl[t].k9, tbl[t].v9);
            check_events($sformatf("vec%0d", t), 1, tbl[t].k10, tbl[t].v10);
        end

        // Reset during press debounce: asynchronous clear, no late strobe
        mode = 1'b0;
        wait_col(4'b1011);
        pressed = 6;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_async_col", col9 == 4'b1110, $sformatf("kp_col=%b want 1110", col9));
        check("rst_async_out", {if9.digito, if9.digito_stb, if9.monto, if9.monto_stb, if9.monto_err, if9.beep} == '0,
              $sformatf("digito=%0d monto=%0d want 0", if9.digito, if9.monto));
        repeat (2) @(negedge clk);
        pressed = -1;
        @(negedge clk);
        rst = 1'b1;
        model_reset(1'b0);
        clear_counts();
        repeat (40) @(negedge clk);
        check_events("rst_no_strobe", 0, EV_NONE, 0);
        check_events("rst_no_strobe", 1, EV_NONE, 0);

        // Random keys and mode flips against the model
        for (int r = 0; r < 40; r++) begin
            bit md = ($urandom_range(0, 4) == 0) ? ~mode : mode;
            int code = $urandom_range(0, 15);
            ev_e k9, k10;
            longint unsigned v9, v10;
            if (r == 0) md = 1'b1;
            apply_key(md, code);
            model_key(0, md, code, k9, v9);
            model_key(1, md, code, k10, v10);
            check_events($sformatf("rnd%0d_key%0d", r, code), 0, k9, v9);
            check_events($sformatf("rnd%0d_key%0d", r, code), 1, k10, v10);
        end

        check("strobe_rules", aux_bad == 0, $sformatf("%0d strobe/add_digit/beep violations, want 0", aux_bad));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
